// File: rtl/adcfifo_wr_packer_if.sv
// Sample stream from the ADC sampler into the FIFO write packer.
interface adcfifo_wr_packer_if #(
   parameter int IN_WIDTH = 16
);
   logic [IN_WIDTH-1:0] s_data;
   logic                s_valid;
   logic                s_last;
   logic                s_ready;

   modport master (output s_data, output s_valid, output s_last, input s_ready);
   modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/adcfifo_wr_packer.sv
// Packs PACK narrow ADC samples into one FIFO word and feeds the FIFO write port
// through a 2-entry skid queue; backpressure reaches the sampler via s_ready.
module adcfifo_wr_packer #(
   parameter int IN_WIDTH  = 16,
   parameter int PACK      = 4,
   parameter int WRITE_LOW = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   adcfifo_wr_packer_if.slave       s,
   input  logic                     fifo_full,
   output logic                     fifo_wr_en,
   output logic [IN_WIDTH*PACK-1:0] fifo_din,
   output logic [15:0]              words_wr,
   output logic                     partial_wr
);
   localparam int W  = IN_WIDTH * PACK;
   localparam int LW = (PACK > 1) ? $clog2(PACK) : 1;
   localparam logic [LW-1:0] LAST_LANE = LW'(PACK - 1);

   logic          running;
   logic [LW-1:0] lane, lane_nxt;
   logic [W-1:0]  asm_q, asm_nxt, word;
   logic [W-1:0]  q_data [2];
   logic          q_pad  [2];
   logic [1:0]    q_cnt;
   logic          accept, complete, pad, push, wr;
   int unsigned   base;

   // running keeps s_ready low while reset is held, without a path from any data input
   assign s.s_ready  = running && (q_cnt != 2'd2);
   assign accept     = s.s_valid && s.s_ready;
   assign wr         = (q_cnt != 2'd0) && !fifo_full;
   assign fifo_wr_en = (WRITE_LOW != 0) ? !wr : wr;
   assign fifo_din   = q_data[0];

   always_comb begin
      base     = 32'(lane) * IN_WIDTH;
      word     = asm_q;
      word[base +: IN_WIDTH] = s.s_data;
      complete = (lane == LAST_LANE) || s.s_last;
      pad      = s.s_last && (lane != LAST_LANE);
      push     = accept && complete;
      lane_nxt = lane;
      asm_nxt  = asm_q;
      if (accept) begin
         if (complete) begin
            lane_nxt = '0;
            asm_nxt  = '0;
         end else begin
            lane_nxt = lane + 1'b1;
            asm_nxt  = word;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         running    <= 1'b0;
         lane       <= '0;
         asm_q      <= '0;
         q_data[0]  <= '0;
         q_data[1]  <= '0;
         q_pad[0]   <= 1'b0;
         q_pad[1]   <= 1'b0;
         q_cnt      <= '0;
         words_wr   <= '0;
         partial_wr <= 1'b0;
      end else begin
         running <= 1'b1;
         lane    <= lane_nxt;
         asm_q   <= asm_nxt;
         // entry 0 is always the head; a pop shifts entry 1 down, a push lands behind it
         case ({push, wr})
            2'b01: begin
               q_data[0] <= q_data[1];
               q_pad[0]  <= q_pad[1];
               q_cnt     <= q_cnt - 2'd1;
            end
            2'b10: begin
               if (q_cnt == 2'd0) begin
                  q_data[0] <= word;
                  q_pad[0]  <= pad;
               end else begin
                  q_data[1] <= word;
                  q_pad[1]  <= pad;
               end
               q_cnt <= q_cnt + 2'd1;
            end
            2'b11: begin
               if (q_cnt == 2'd1) begin
                  q_data[0] <= word;
                  q_pad[0]  <= pad;
               end else begin
                  q_data[0] <= q_data[1];
                  q_pad[0]  <= q_pad[1];
                  q_data[1] <= word;
                  q_pad[1]  <= pad;
               end
            end
            default: ;
         endcase
         if (wr) begin
            words_wr   <= words_wr + 16'd1;
            partial_wr <= partial_wr | q_pad[0];
         end
      end
   end
endmodule

// File: tb/tb_adcfifo_wr_packer.sv
// Scoreboard bench: a PACK=4 active-low-write instance under directed and random
// traffic, plus a PACK=1 active-high instance exercising the 16-bit write counter wrap.
module tb_adcfifo_wr_packer;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst1, rst2, full1, full2;
   logic        wr_en1, wr_en2, part_wr1, part_wr2;
   logic [63:0] din1;
   logic [15:0] din2;
   logic [15:0] words1, words2;

   adcfifo_wr_packer_if #(.IN_WIDTH(16)) sif1 ();
   adcfifo_wr_packer_if #(.IN_WIDTH(16)) sif2 ();

   adcfifo_wr_packer #(.IN_WIDTH(16), .PACK(4), .WRITE_LOW(1)) dut1 (
      .clk(clk), .rst(rst1), .s(sif1), .fifo_full(full1), .fifo_wr_en(wr_en1),
      .fifo_din(din1), .words_wr(words1), .partial_wr(part_wr1));

   adcfifo_wr_packer #(.IN_WIDTH(16), .PACK(1), .WRITE_LOW(0)) dut2 (
      .clk(clk), .rst(rst2), .s(sif2), .fifo_full(full2), .fifo_wr_en(wr_en2),
      .fifo_din(din2), .words_wr(words2), .partial_wr(part_wr2));

   int n_checks = 0;
   int n_pass   = 0;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endfunction

   // ---------------- reference model for dut1 (PACK=4) ----------------
   typedef struct { logic [63:0] data; bit pad; } exp_t;
   typedef struct { logic [15:0] d; bit last; } smp_t;

   exp_t        exp1_q[$];
   logic [15:0] lanes1[$];
   smp_t        tx1_q[$];
   int          produced1 = 0, written1 = 0, accepted1 = 0, gap_pct = 0;
   bit          part1 = 0, have1 = 0, toggle_full = 0;
   smp_t        cur1;

   function automatic void model1_accept(logic [15:0] d, bit last);
      exp_t e;
      lanes1.push_back(d);
      if (lanes1.size() == 4 || last) begin
         e.data = '0;
         foreach (lanes1[i]) e.data = e.data | (64'(lanes1[i]) << (16 * i));
         e.pad = last && (lanes1.size() < 4);
         exp1_q.push_back(e);
         lanes1.delete();
         produced1++;
      end
   endfunction

   initial begin
      sif1.s_valid = 1'b0; sif1.s_data = '0; sif1.s_last = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (toggle_full) full1 = ~full1;
         if (!have1 && tx1_q.size() > 0) begin
            cur1  = tx1_q.pop_front();
            have1 = 1'b1;
         end
         if (have1 && $urandom_range(99) >= gap_pct) begin
            sif1.s_valid = 1'b1; sif1.s_data = cur1.d; sif1.s_last = cur1.last;
         end else begin
            sif1.s_valid = 1'b0; sif1.s_data = 16'($urandom); sif1.s_last = 1'($urandom);
         end
         @(negedge clk);
         if (sif1.s_valid && sif1.s_ready) begin
            model1_accept(cur1.d, cur1.last);
            have1 = 1'b0;
            accepted1++;
         end
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst1) check("rst_wr_inactive", 64'(wr_en1), 64'd1);
         else if (wr_en1 == 1'b0) begin
            check("no_write_while_full", 64'(full1), 64'd0);
            check("words_wr_track", 64'(words1), 64'(16'(written1)));
            check("partial_wr_track", 64'(part_wr1), 64'(part1));
            check("write_has_expected_word", 64'(exp1_q.size() != 0), 64'd1);
            if (exp1_q.size() != 0) begin
               e = exp1_q.pop_front();
               check("fifo_din", din1, e.data);
               written1++;
               part1 = part1 | e.pad;
            end
         end
      end
   end

   // ---------------- dut2: PACK=1, active-high, counter wrap ----------------
   localparam int N2 = 65540;
   logic [15:0] exp2_q[$];
   int          acc2 = 0, written2 = 0;

   initial begin
      sif2.s_valid = 1'b0; sif2.s_data = '0; sif2.s_last = 1'b0;
      @(posedge rst2);
      for (int cyc = 0; cyc < 70000 && acc2 < N2; cyc++) begin
         @(posedge clk); #1;
         sif2.s_valid = 1'b1; sif2.s_data = 16'($urandom); sif2.s_last = 1'($urandom);
         @(negedge clk);
         if (sif2.s_valid && sif2.s_ready) begin
            exp2_q.push_back(sif2.s_data);
            acc2++;
         end
      end
      @(posedge clk); #1;
      sif2.s_valid = 1'b0;
   end

   initial begin
      logic [15:0] e2;
      forever begin
         @(negedge clk);
         if (rst2 && wr_en2) begin
            if (written2 == 65535) check("w2_pre_wrap", 64'(words2), 64'h0000_0000_0000_FFFF);
            if (written2 == 65536) check("w2_wrapped", 64'(words2), 64'd0);
            check("w2_has_expected_word", 64'(exp2_q.size() != 0), 64'd1);
            if (exp2_q.size() != 0) begin
               e2 = exp2_q.pop_front();
               check("w2_fifo_din", 64'(din2), 64'(e2));
               written2++;
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic push_smp(logic [15:0] d, bit last);
      smp_t s;
      s.d = d; s.last = last;
      tx1_q.push_back(s);
   endtask

   task automatic wait_tx_empty(int budget);
      int n = 0;
      while ((tx1_q.size() != 0 || have1) && n < budget) begin
         @(posedge clk);
         n++;
      end
      check("tx_drained_in_budget", 64'(tx1_q.size() == 0 && !have1), 64'd1);
   endtask

   task automatic wait_drain(int budget);
      int n = 0;
      while (exp1_q.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      check("queue_drained_in_budget", 64'(exp1_q.size()), 64'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int a0;
      int w0;
      rst1 = 1'b0; rst2 = 1'b0; full1 = 1'b0; full2 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_s_ready", 64'(sif1.s_ready), 64'd0);
      check("rst_wr_en_low_pol", 64'(wr_en1), 64'd1);
      check("rst_wr_en_high_pol", 64'(wr_en2), 64'd0);
      check("rst_din", din1, 64'd0);
      check("rst_words", 64'(words1), 64'd0);
      check("rst_partial", 64'(part_wr1), 64'd0);
      rst1 = 1'b1; rst2 = 1'b1;

      // 1: four back-to-back samples, write one cycle after the 4th accept
      push_smp(16'h1111, 0); push_smp(16'h2222, 0); push_smp(16'h3333, 0); push_smp(16'h4444, 0);
      wait_tx_empty(50);
      @(negedge clk);
      check("t1_write_latency", 64'(wr_en1), 64'd0);
      check("t1_word", din1, 64'h4444_3333_2222_1111);
      wait_drain(50);
      check("t1_words_wr", 64'(words1), 64'd1);

      // 2: padded word, then a fresh word starting at lane 0
      push_smp(16'hAAAA, 0); push_smp(16'hBBBB, 1);
      wait_tx_empty(50);
      wait_drain(50);
      check("t2_partial_wr", 64'(part_wr1), 64'd1);
      push_smp(16'h0001, 0); push_smp(16'h0002, 0); push_smp(16'h0003, 0); push_smp(16'h0004, 0);
      wait_tx_empty(50);
      wait_drain(50);

      // 3: full holds the queue, ready drops after 8 samples, release writes back-to-back
      @(posedge clk); #1;
      full1 = 1'b1;
      a0 = accepted1;
      w0 = written1;
      for (int i = 0; i < 12; i++) push_smp(16'(16'h3000 + i), 0);
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("t3_accepted_before_stall", 64'(accepted1 - a0), 64'd8);
      check("t3_s_ready_low", 64'(sif1.s_ready), 64'd0);
      check("t3_no_write", 64'(written1 - w0), 64'd0);
      @(posedge clk); #1;
      full1 = 1'b0;
      @(negedge clk);
      check("t3_release_write0", 64'(wr_en1), 64'd0);
      @(negedge clk);
      check("t3_release_write1", 64'(wr_en1), 64'd0);
      wait_tx_empty(100);
      wait_drain(100);
      check("t3_words_in_order", 64'(written1 - w0), 64'd3);

      // 4: full toggling every cycle with random traffic
      gap_pct = 30;
      toggle_full = 1'b1;
      for (int i = 0; i < 200; i++) push_smp(16'($urandom), ($urandom_range(7) == 0));
      wait_tx_empty(3000);
      toggle_full = 1'b0;
      @(posedge clk); #2;
      full1 = 1'b0;
      if (lanes1.size() != 0) push_smp(16'($urandom), 1);
      wait_tx_empty(100);
      wait_drain(100);
      check("t4_words_wr_vs_model", 64'(words1), 64'(16'(produced1)));
      gap_pct = 0;

      // 5: reset with 2 lanes filled and 1 word queued
      @(posedge clk); #1;
      full1 = 1'b1;
      for (int i = 0; i < 6; i++) push_smp(16'(16'h5000 + i), 0);
      wait_tx_empty(50);
      repeat (2) @(posedge clk);
      #1;
      rst1 = 1'b0;
      #1;
      check("t5_wr_inactive", 64'(wr_en1), 64'd1);
      check("t5_s_ready_low", 64'(sif1.s_ready), 64'd0);
      check("t5_din_cleared", din1, 64'd0);
      check("t5_words_cleared", 64'(words1), 64'd0);
      check("t5_partial_cleared", 64'(part_wr1), 64'd0);
      exp1_q.delete(); lanes1.delete();
      written1 = 0; produced1 = 0; part1 = 0;
      @(posedge clk); #1;
      full1 = 1'b0;
      rst1 = 1'b1;
      push_smp(16'h6001, 0); push_smp(16'h6002, 0); push_smp(16'h6003, 0); push_smp(16'h6004, 0);
      wait_tx_empty(50);
      @(negedge clk);
      check("t5_fresh_word", din1, 64'h6004_6003_6002_6001);
      wait_drain(50);
      check("t5_words_wr", 64'(words1), 64'd1);

      // 6: PACK=1 instance completes its run and wraps words_wr
      for (int n = 0; n < 80000 && (acc2 < N2 || exp2_q.size() != 0); n++) @(posedge clk);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("t6_all_accepted", 64'(acc2), 64'(N2));
      check("t6_all_written", 64'(written2), 64'(N2));
      check("t6_words_wr_wrapped", 64'(words2), 64'(16'(N2)));
      check("t6_no_partial", 64'(part_wr2), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
